// File: rtl/link_master_arbiter_if.sv
// Byte link between the arbitrating master and the slave.
// The master drives req/data; the slave answers with ack.
interface link_master_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              link_req;
   logic [DATA_W-1:0] link_data;
   logic              link_ack;

   modport master (output link_req, output link_data, input link_ack);
   modport slave  (input link_req, input link_data, output link_ack);
endinterface

// File: rtl/link_master_arbiter.sv
// Round-robin master for the req/ack byte link, sharing it between NUM_CLIENTS producers.
// Define ACK_TIMEOUT_EN to abort a request that is not acknowledged within TIMEOUT_CYCLES.
module link_master_arbiter #(
   parameter int  NUM_CLIENTS    = 4,
   parameter int  DATA_W         = 8,
   parameter int  TIMEOUT_CYCLES = 16,
   localparam int ID_W           = $clog2(NUM_CLIENTS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CLIENTS-1:0]        client_valid,
   input  logic [NUM_CLIENTS*DATA_W-1:0] client_data,
   output logic [NUM_CLIENTS-1:0]        client_done,
   link_master_arbiter_if.master         link,
   output logic                          busy,
   output logic [ID_W-1:0]               grant_id,
   output logic [15:0]                   xfer_count,
   output logic                          timeout_err
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   link_req_q, link_req_d;
   logic [DATA_W-1:0]      link_data_q, link_data_d;
   logic [NUM_CLIENTS-1:0] client_done_q, client_done_d;
   logic                   busy_q, busy_d;
   logic [ID_W-1:0]        grant_id_q, grant_id_d;
   logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [15:0]            xfer_count_q, xfer_count_d;

   logic [ID_W-1:0]        cand_idx [NUM_CLIENTS];
   logic [NUM_CLIENTS-1:0] cand_valid;
   logic [ID_W-1:0]        pick_idx;
   logic                   pick_found;
   logic [DATA_W-1:0]      pick_data;
   logic [ID_W-1:0]        rr_next;

`ifdef ACK_TIMEOUT_EN
   logic [7:0] wait_q, wait_d;
   logic       timeout_err_q, timeout_err_d;
`endif

   // Candidate gi is the client gi positions after rr_ptr, so lower gi means higher priority.
   for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_cand
      assign cand_idx[gi]   = ID_W'((32'(rr_ptr_q) + 32'(gi)) % 32'(NUM_CLIENTS));
      assign cand_valid[gi] = client_valid[cand_idx[gi]];
   end

   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
         if (cand_valid[k]) begin
            pick_idx   = cand_idx[k];
            pick_found = 1'b1;
         end
      end
   end

   assign pick_data = client_data[32'(pick_idx) * DATA_W +: DATA_W];
   assign rr_next   = ID_W'((32'(grant_id_q) + 32'd1) % 32'(NUM_CLIENTS));

   always_comb begin
      state_d       = state_q;
      link_req_d    = link_req_q;
      link_data_d   = link_data_q;
      grant_id_d    = grant_id_q;
      rr_ptr_d      = rr_ptr_q;
      xfer_count_d  = xfer_count_q;
      client_done_d = '0;
`ifdef ACK_TIMEOUT_EN
      wait_d        = wait_q;
      timeout_err_d = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            // A stale ack from the previous transfer holds off the next grant.
            if (pick_found && !link.link_ack) begin
               state_d     = S_REQ;
               link_req_d  = 1'b1;
               link_data_d = pick_data;
               grant_id_d  = pick_idx;
`ifdef ACK_TIMEOUT_EN
               wait_d      = '0;
`endif
            end
         end
         S_REQ: begin
            if (link.link_ack) begin
               state_d                   = S_DROP;
               link_req_d                = 1'b0;
               client_done_d[grant_id_q] = 1'b1;
               xfer_count_d              = xfer_count_q + 16'd1;
               rr_ptr_d                  = rr_next;
            end
`ifdef ACK_TIMEOUT_EN
            else if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
               state_d                   = S_DROP;
               link_req_d                = 1'b0;
               client_done_d[grant_id_q] = 1'b1;
               rr_ptr_d                  = rr_next;
               timeout_err_d             = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
`endif
         end
         S_DROP: begin
            if (!link.link_ack) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d    = S_IDLE;
            link_req_d = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         link_req_q    <= 1'b0;
         link_data_q   <= '0;
         client_done_q <= '0;
         busy_q        <= 1'b0;
         grant_id_q    <= '0;
         rr_ptr_q      <= '0;
         xfer_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         link_req_q    <= link_req_d;
         link_data_q   <= link_data_d;
         client_done_q <= client_done_d;
         busy_q        <= busy_d;
         grant_id_q    <= grant_id_d;
         rr_ptr_q      <= rr_ptr_d;
         xfer_count_q  <= xfer_count_d;
      end
   end

`ifdef ACK_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q        <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wait_q        <= wait_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   // Keeps the timeout parameter referenced in builds without the abort logic.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_err        = 1'b0;
`endif

   assign link.link_req  = link_req_q;
   assign link.link_data = link_data_q;
   assign client_done    = client_done_q;
   assign busy           = busy_q;
   assign grant_id       = grant_id_q;
   assign xfer_count     = xfer_count_q;
endmodule
